// File: rtl/csi2_rx_pkg.sv
// Shared CSI-2 receive types: LP line states, HS lane sequencer states and the default
// HS sync byte.
package csi2_rx_pkg;

   typedef enum logic [1:0] {
      LP00 = 2'b00,
      LP01 = 2'b01,
      LP10 = 2'b10,
      LP11 = 2'b11
   } lp_state_t;

   typedef enum logic [2:0] {
      StWaitStop,
      StIdle,
      StHsRqst,
      StSettle,
      StSearch,
      StHsRx
   } hs_ctrl_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/sync_byte_finder.sv
// Combinational search for the HS sync byte at any of 8 bit offsets in a 16-bit window;
// window[15] is the oldest bit and the lowest matching offset wins.
module sync_byte_finder (
   input  logic [15:0] window,
   input  logic [7:0]  pattern,
   output logic        match,
   output logic [2:0]  offset
);

   always_comb begin
      match  = 1'b0;
      offset = 3'd0;
      // Descending scan so the lowest matching offset is the one left standing.
      for (int k = 7; k >= 0; k--) begin
         if (8'(window >> (8 - k)) == pattern) begin
            match  = 1'b1;
            offset = 3'(k);
         end
      end
   end

endmodule

// File: rtl/dphy_hs_lane_ctrl.sv
// D-PHY HS receive lane sequencer: detects LP-11/01/00 start of transmission, waits out
// HS settle, locks onto the sync byte and emits byte-aligned payload with sot/eot markers.
module dphy_hs_lane_ctrl
   import csi2_rx_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 6,
   parameter int unsigned SYNC_TIMEOUT  = 32,
   parameter logic [7:0]  SYNC_PATTERN  = SYNC_BYTE
) (
   input  logic       byte_clk_i,
   input  logic       rst_i,
   input  logic       lp_data_p_i,
   input  logic       lp_data_n_i,
   input  logic [7:0] byte_data_i,
   output logic       hs_enable_o,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       sot_o,
   output logic       eot_o,
   output logic       err_sot_o
);

   logic           p_meta, p_sync, n_meta, n_sync;
   lp_state_t      lp;
   logic [7:0]     r1, r2;
   logic [15:0]    win;
   logic           match;
   logic [2:0]     match_offset;
   hs_ctrl_state_t state, state_next;
   logic [7:0]     cnt, cnt_next;
   logic [2:0]     k, k_next;
   logic           hs_en_next, valid_next, sot_next, eot_next, err_next;
   logic [7:0]     data_next;

   assign lp  = lp_state_t'({p_sync, n_sync});
   assign win = {r2, r1};

   sync_byte_finder u_finder (
      .window  (win),
      .pattern (SYNC_PATTERN),
      .match   (match),
      .offset  (match_offset)
   );

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      k_next     = k;
      hs_en_next = hs_enable_o;
      valid_next = 1'b0;
      data_next  = data_o;
      eot_next   = 1'b0;
      err_next   = 1'b0;
      unique case (state)
         StWaitStop: begin
            if (lp == LP11) state_next = StIdle;
         end
         StIdle: begin
            if (lp == LP01) state_next = StHsRqst;
            else if (lp == LP10) state_next = StWaitStop;
         end
         StHsRqst: begin
            if (lp == LP00) begin
               state_next = StSettle;
               cnt_next   = 8'd0;
               hs_en_next = 1'b1;
            end else if (lp == LP11) begin
               state_next = StIdle;
            end else if (lp == LP10) begin
               state_next = StWaitStop;
            end
         end
         StSettle: begin
            if (lp == LP11) begin
               state_next = StIdle;
               hs_en_next = 1'b0;
            end else if (cnt == 8'(SETTLE_CYCLES - 1)) begin
               state_next = StSearch;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         StSearch: begin
            // Stop state outranks a match or a timeout in the same cycle.
            if (lp == LP11) begin
               state_next = StIdle;
               hs_en_next = 1'b0;
            end else if (match) begin
               state_next = StHsRx;
               k_next     = match_offset;
            end else if (cnt == 8'(SYNC_TIMEOUT - 1)) begin
               state_next = StWaitStop;
               hs_en_next = 1'b0;
               err_next   = 1'b1;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         StHsRx: begin
            if (lp == LP11) begin
               state_next = StIdle;
               hs_en_next = 1'b0;
               eot_next   = 1'b1;
            end else begin
               valid_next = 1'b1;
               data_next  = 8'(win >> (4'd8 - 4'(k)));
            end
         end
         default: state_next = StWaitStop;
      endcase
      // The first HS_RX cycle always follows a cycle with valid low.
      sot_next = valid_next & ~valid_o;
   end

   always_ff @(posedge byte_clk_i) begin
      if (rst_i) begin
         p_meta      <= 1'b0;
         p_sync      <= 1'b0;
         n_meta      <= 1'b0;
         n_sync      <= 1'b0;
         r1          <= 8'd0;
         r2          <= 8'd0;
         state       <= StWaitStop;
         cnt         <= 8'd0;
         k           <= 3'd0;
         hs_enable_o <= 1'b0;
         data_o      <= 8'd0;
         valid_o     <= 1'b0;
         sot_o       <= 1'b0;
         eot_o       <= 1'b0;
         err_sot_o   <= 1'b0;
      end else begin
         p_meta      <= lp_data_p_i;
         p_sync      <= p_meta;
         n_meta      <= lp_data_n_i;
         n_sync      <= n_meta;
         r1          <= byte_data_i;
         r2          <= r1;
         state       <= state_next;
         cnt         <= cnt_next;
         k           <= k_next;
         hs_enable_o <= hs_en_next;
         data_o      <= data_next;
         valid_o     <= valid_next;
         sot_o       <= sot_next;
         eot_o       <= eot_next;
         err_sot_o   <= err_next;
      end
   end

endmodule

// File: tb/tb_dphy_hs_lane_ctrl.sv
// Self-checking bench for dphy_hs_lane_ctrl: directed LP sequences plus randomized bursts
// checked cycle by cycle against a timeline model derived from the sequencing rules.
module tb_dphy_hs_lane_ctrl;

   localparam int         S    = 6;
   localparam int         T    = 32;
   localparam int         N    = 8192;
   localparam logic [7:0] SYNC = 8'hB8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lp_p = 1'b0;
   logic       lp_n = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       hs_en, vld, sot, eot, err;
   logic [7:0] dout;

   dphy_hs_lane_ctrl dut (
      .byte_clk_i  (clk),
      .rst_i       (rst),
      .lp_data_p_i (lp_p),
      .lp_data_n_i (lp_n),
      .byte_data_i (byte_in),
      .hs_enable_o (hs_en),
      .data_o      (dout),
      .valid_o     (vld),
      .sot_o       (sot),
      .eot_o       (eot),
      .err_sot_o   (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle logs: bytes driven, and outputs seen ({hs, valid, sot, eot, err}).
   logic [7:0] in_log  [N];
   logic [4:0] flg_log [N];
   logic [7:0] dat_log [N];
   always @(negedge clk) begin
      flg_log[cyc] = {hs_en, vld, sot, eot, err};
      dat_log[cyc] = dout;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input int c, input logic [12:0] obs,
                        input logic [12:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cyc %0d: got %h expected %h", tag, c, obs, exp);
      end
   endtask

   task automatic step(input logic p, input logic n, input logic [7:0] b,
                       input logic r = 1'b0);
      @(negedge clk);
      rst         = r;
      lp_p        = p;
      lp_n        = n;
      byte_in     = b;
      in_log[cyc] = b;
   endtask

   function automatic logic [7:0] fill(input logic rnd);
      return rnd ? 8'($urandom) : 8'h00;
   endfunction

   // Byte at bit offset k of the window {byte two cycles back, byte one cycle back}.
   function automatic logic [7:0] cand(input int t, input int k);
      logic [15:0] w;
      w = {in_log[t-2], in_log[t-1]};
      return 8'(w >> (8 - k));
   endfunction

   task automatic build(input int g, input logic [7:0] pay[$], input logic sync_on,
                        input logic rnd, output logic [7:0] s[$]);
      logic       bq[$];
      logic [7:0] b;
      s = {};
      for (int i = 0; i < g; i++) bq.push_back(rnd ? 1'($urandom) : 1'b0);
      if (sync_on) begin
         b = SYNC;
         for (int j = 7; j >= 0; j--) bq.push_back(b[j]);
      end
      foreach (pay[i]) begin
         b = pay[i];
         for (int j = 7; j >= 0; j--) bq.push_back(b[j]);
      end
      while (bq.size() % 8 != 0) bq.push_back(rnd ? 1'($urandom) : 1'b0);
      for (int i = 0; i < 16; i++) bq.push_back(rnd ? 1'($urandom) : 1'b0);
      for (int i = 0; i < bq.size(); i += 8) begin
         for (int j = 0; j < 8; j++) b[7-j] = bq[i+j];
         s.push_back(b);
      end
   endtask

   // LP-11, LP-01, then LP-00 carrying the stream from its 8th cycle, then LP-11.
   task automatic burst(input logic [7:0] s[$], input int extra, input int h_min,
                        input logic rnd, output int c0, output int c1);
      int h;
      h = 7 + s.size() + extra;
      if (h < h_min) h = h_min;
      repeat (4) step(1'b1, 1'b1, fill(rnd));
      repeat (3) step(1'b0, 1'b1, fill(rnd));
      c0 = cyc + 1;
      for (int i = 0; i < h; i++)
         step(1'b0, 1'b0, (i >= 7 && i - 7 < s.size()) ? s[i-7] : fill(rnd));
      c1 = cyc + 1;
      repeat (7) step(1'b1, 1'b1, fill(rnd));
   endtask

   // Timeline model: c0 = first LP-00 drive cycle, c1 = first LP-11 drive cycle.
   task automatic check_burst(input int c0, input int c1, input string tag);
      int         s0, stop, mt, mk, hs_end;
      logic       to, e_hs, e_v, e_so, e_eo, e_er;
      logic [7:0] e_d, o_d;
      s0   = c0 + 3 + S;
      stop = c1 + 2;
      mt   = -1;
      mk   = 0;
      for (int t = s0; t < s0 + T && t < stop && mt < 0; t++)
         for (int k = 0; k < 8 && mt < 0; k++)
            if (cand(t, k) == SYNC) begin
               mt = t;
               mk = k;
            end
      to     = (mt < 0) && (s0 + T <= stop);
      hs_end = to ? s0 + T : stop + 1;
      for (int c = c0 - 2; c <= c1 + 5; c++) begin
         e_hs = (c >= c0 + 3) && (c < hs_end);
         e_v  = (mt >= 0) && (c >= mt + 2) && (c <= stop);
         e_so = e_v && (c == mt + 2);
         e_eo = (mt >= 0) && (c == stop + 1);
         e_er = to && (c == s0 + T);
         e_d  = e_v ? cand(c - 1, mk) : 8'h00;
         o_d  = e_v ? dat_log[c] : 8'h00;
         check(tag, c, {flg_log[c], o_d}, {e_hs, e_v, e_so, e_eo, e_er, e_d});
      end
   endtask

   task automatic check_quiet(input int from, input int to, input string tag);
      for (int c = from; c <= to; c++) check(tag, c, {flg_log[c], 8'h00}, 13'd0);
   endtask

   task automatic collect(input int from, input int to, output logic [7:0] got[$],
                          output int nsot, output int neot, output int nerr);
      got  = {};
      nsot = 0;
      neot = 0;
      nerr = 0;
      for (int c = from; c <= to; c++) begin
         if (flg_log[c][3]) got.push_back(dat_log[c]);
         nsot += int'(flg_log[c][2]);
         neot += int'(flg_log[c][1]);
         nerr += int'(flg_log[c][0]);
      end
   endtask

   initial begin
      logic [7:0] s[$], pay[$], got[$];
      int         c0, c1, cs, nsot, neot, nerr, g, len, extra;
      logic       sync_on;

      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
      check("reset", cyc, {hs_en, vld, sot, eot, err, dout}, 13'd0);

      // Nominal burst, sync at offset 0.
      pay = {8'h01, 8'h02, 8'h03};
      build(0, pay, 1'b1, 1'b0, s);
      burst(s, 2, 0, 1'b0, c0, c1);
      check_burst(c0, c1, "nom");
      collect(c0, c1 + 5, got, nsot, neot, nerr);
      check("nom_b0", c0, {5'd0, got[0]}, {5'd0, 8'h01});
      check("nom_b1", c0, {5'd0, got[1]}, {5'd0, 8'h02});
      check("nom_b2", c0, {5'd0, got[2]}, {5'd0, 8'h03});
      check("nom_sot", c0, 13'(nsot), 13'd1);
      check("nom_eot", c0, 13'(neot), 13'd1);
      check("nom_hs_off", c1 + 5, {12'd0, flg_log[c1+5][4]}, 13'd0);

      // Sync shifted by 5 bits.
      pay = {8'hAA, 8'h55, 8'hC3};
      build(5, pay, 1'b1, 1'b0, s);
      burst(s, 1, 0, 1'b0, c0, c1);
      check_burst(c0, c1, "off5");
      collect(c0, c1 + 5, got, nsot, neot, nerr);
      check("off5_b0", c0, {5'd0, got[0]}, {5'd0, 8'hAA});
      check("off5_b1", c0, {5'd0, got[1]}, {5'd0, 8'h55});
      check("off5_b2", c0, {5'd0, got[2]}, {5'd0, 8'hC3});

      // No sync byte: timeout.
      pay = {};
      build(0, pay, 1'b0, 1'b0, s);
      burst(s, 0, 45, 1'b0, c0, c1);
      check_burst(c0, c1, "timeout");
      collect(c0, c1 + 5, got, nsot, neot, nerr);
      check("timeout_err", c0, 13'(nerr), 13'd1);
      check("timeout_valid", c0, 13'(got.size()), 13'd0);

      // Aborted request: 11 -> 01 -> 11.
      cs = cyc + 1;
      repeat (4) step(1'b1, 1'b1, 8'h00);
      repeat (3) step(1'b0, 1'b1, 8'h00);
      repeat (4) step(1'b1, 1'b1, 8'h00);
      repeat (12) step(1'b0, 1'b0, 8'h00);
      repeat (2) step(1'b1, 1'b1, 8'h00);
      check_quiet(cs, cyc - 1, "abort");

      // Escape entry: 10 puts the lane back in stop wait, so 01/00 is ignored.
      cs = cyc + 1;
      repeat (4) step(1'b1, 1'b1, 8'h00);
      repeat (3) step(1'b1, 1'b0, 8'h00);
      repeat (3) step(1'b0, 1'b1, 8'h00);
      repeat (20) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      check_quiet(cs, cyc - 1, "escape");

      // Reset in the middle of payload, then a request without LP-11 first.
      pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      build(0, pay, 1'b1, 1'b0, s);
      repeat (4) step(1'b1, 1'b1, 8'h00);
      repeat (3) step(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 13; i++) step(1'b0, 1'b0, (i >= 7) ? s[i-7] : 8'h00);
      step(1'b0, 1'b0, s[6], 1'b1);
      cs = cyc;
      step(1'b0, 1'b0, 8'h00);
      check("rst_pre_valid", cs, {12'd0, flg_log[cs][3]}, 13'd1);
      check("rst_mid", cyc, {hs_en, vld, sot, eot, err, dout}, 13'd0);
      cs = cyc;
      repeat (3) step(1'b0, 1'b1, 8'h00);
      repeat (40) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      check_quiet(cs, cyc - 1, "rst_no_stop");

      // Randomized bursts.
      for (int it = 0; it < 12; it++) begin
         g       = $urandom_range(0, 23);
         len     = $urandom_range(1, 5);
         extra   = $urandom_range(0, 3);
         sync_on = ($urandom_range(0, 4) != 0);
         pay     = {};
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
         build(g, pay, sync_on, 1'b1, s);
         burst(s, extra, sync_on ? 0 : 45, 1'b1, c0, c1);
         check_burst(c0, c1, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
